// File: rtl/itch_pkg.sv
// Shared constants and types for the ITCH Add/Cancel/Delete decoders:
// type bytes, message lengths, field byte offsets and parsed-type codes.
package itch_pkg;

  localparam int CNT_W = 6;

  localparam logic [7:0] TYPE_ADD    = 8'h41;
  localparam logic [7:0] TYPE_CANCEL = 8'h58;
  localparam logic [7:0] TYPE_DELETE = 8'h44;
  localparam logic [7:0] SIDE_SELL   = 8'h53;

  localparam int LEN_ADD    = 36;
  localparam int LEN_CANCEL = 23;
  localparam int LEN_DELETE = 19;

  localparam logic [CNT_W-1:0] OFF_OREF_LO      = 6'd11;
  localparam logic [CNT_W-1:0] OFF_OREF_HI      = 6'd18;
  localparam logic [CNT_W-1:0] OFF_ADD_SIDE     = 6'd19;
  localparam logic [CNT_W-1:0] OFF_ADD_SHR_LO   = 6'd20;
  localparam logic [CNT_W-1:0] OFF_ADD_SHR_HI   = 6'd23;
  localparam logic [CNT_W-1:0] OFF_ADD_SYM_LO   = 6'd24;
  localparam logic [CNT_W-1:0] OFF_ADD_SYM_HI   = 6'd31;
  localparam logic [CNT_W-1:0] OFF_ADD_PRICE_LO = 6'd32;
  localparam logic [CNT_W-1:0] OFF_ADD_PRICE_HI = 6'd35;
  localparam logic [CNT_W-1:0] OFF_CXL_SHR_LO   = 6'd19;
  localparam logic [CNT_W-1:0] OFF_CXL_SHR_HI   = 6'd22;

  localparam logic [3:0] PT_ADD     = 4'd1;
  localparam logic [3:0] PT_CANCEL  = 4'd2;
  localparam logic [3:0] PT_DELETE  = 4'd3;
  localparam logic [3:0] PT_REPLACE = 4'd4;
  localparam logic [3:0] PT_EXEC    = 4'd5;
  localparam logic [3:0] PT_TRADE   = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_SKIP   = 2'd2
  } dec_state_t;

  function automatic logic in_field(input logic [CNT_W-1:0] cnt,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/itch_msg_framer.sv
// Per-decoder message framer: tracks the byte offset within a message of one
// type and produces registered done / truncation pulses.
module itch_msg_framer
  import itch_pkg::*;
#(
  parameter logic [7:0] TYPE_BYTE = 8'h00,
  parameter int         LEN       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             valid_in,
  output dec_state_t       state,
  output logic [CNT_W-1:0] cnt,
  output logic             done,
  output logic             trunc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  dec_state_t       next_state;
  logic [CNT_W-1:0] next_cnt;
  logic             next_done;
  logic             next_trunc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      trunc <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      done  <= next_done;
      trunc <= next_trunc;
    end
  end

  // cnt holds the offset of the byte being sampled while ACTIVE
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_done  = 1'b0;
    next_trunc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid_in) begin
          if (byte_in == TYPE_BYTE) begin
            next_state = ST_ACTIVE;
            next_cnt   = CNT_W'(1);
          end else begin
            next_state = ST_SKIP;
          end
        end
      end
      ST_ACTIVE: begin
        if (!valid_in) begin
          next_state = ST_IDLE;
          next_cnt   = '0;
          next_trunc = 1'b1;
        end else if (cnt == LAST) begin
          next_state = ST_SKIP;
          next_cnt   = '0;
          next_done  = 1'b1;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      ST_SKIP: begin
        if (!valid_in) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/itch_acd_decoder.sv
// Speculative ITCH 5.0 decoder for Add ('A'), Cancel ('X') and Delete ('D')
// messages; fields shift in as bytes arrive and are qualified by *_internal_valid.
module itch_acd_decoder
  import itch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        valid_in,
  output logic        add_internal_valid,
  output logic        add_packet_invalid,
  output logic [63:0] add_order_ref,
  output logic        add_side,
  output logic [31:0] add_shares,
  output logic [31:0] add_price,
  output logic [63:0] add_stock_symbol,
  output logic [3:0]  add_parsed_type,
  output logic        cancel_internal_valid,
  output logic        cancel_packet_invalid,
  output logic [63:0] cancel_order_ref,
  output logic [31:0] cancel_canceled_shares,
  output logic [3:0]  cancel_parsed_type,
  output logic        delete_internal_valid,
  output logic [63:0] delete_order_ref,
  output logic [3:0]  delete_parsed_type
);

  dec_state_t       add_state, cancel_state, delete_state;
  logic [CNT_W-1:0] add_cnt, cancel_cnt, delete_cnt;
  logic             delete_trunc_unused;
  logic             add_take, cancel_take, delete_take;

  itch_msg_framer #(.TYPE_BYTE(TYPE_ADD), .LEN(LEN_ADD)) u_add_framer (
    .clk(clk), .rst(rst), .byte_in(byte_in), .valid_in(valid_in),
    .state(add_state), .cnt(add_cnt),
    .done(add_internal_valid), .trunc(add_packet_invalid)
  );

  itch_msg_framer #(.TYPE_BYTE(TYPE_CANCEL), .LEN(LEN_CANCEL)) u_cancel_framer (
    .clk(clk), .rst(rst), .byte_in(byte_in), .valid_in(valid_in),
    .state(cancel_state), .cnt(cancel_cnt),
    .done(cancel_internal_valid), .trunc(cancel_packet_invalid)
  );

  // Delete truncation is silent, so its framer's trunc pulse goes nowhere
  itch_msg_framer #(.TYPE_BYTE(TYPE_DELETE), .LEN(LEN_DELETE)) u_delete_framer (
    .clk(clk), .rst(rst), .byte_in(byte_in), .valid_in(valid_in),
    .state(delete_state), .cnt(delete_cnt),
    .done(delete_internal_valid), .trunc(delete_trunc_unused)
  );

  assign add_take    = valid_in && (add_state == ST_ACTIVE);
  assign cancel_take = valid_in && (cancel_state == ST_ACTIVE);
  assign delete_take = valid_in && (delete_state == ST_ACTIVE);

  assign add_parsed_type    = add_internal_valid    ? PT_ADD    : 4'd0;
  assign cancel_parsed_type = cancel_internal_valid ? PT_CANCEL : 4'd0;
  assign delete_parsed_type = delete_internal_valid ? PT_DELETE : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_order_ref    <= '0;
      add_side         <= 1'b0;
      add_shares       <= '0;
      add_stock_symbol <= '0;
      add_price        <= '0;
    end else if (add_take) begin
      if (in_field(add_cnt, OFF_OREF_LO, OFF_OREF_HI))
        add_order_ref <= {add_order_ref[55:0], byte_in};
      if (add_cnt == OFF_ADD_SIDE)
        add_side <= (byte_in == SIDE_SELL);
      if (in_field(add_cnt, OFF_ADD_SHR_LO, OFF_ADD_SHR_HI))
        add_shares <= {add_shares[23:0], byte_in};
      if (in_field(add_cnt, OFF_ADD_SYM_LO, OFF_ADD_SYM_HI))
        add_stock_symbol <= {add_stock_symbol[55:0], byte_in};
      if (in_field(add_cnt, OFF_ADD_PRICE_LO, OFF_ADD_PRICE_HI))
        add_price <= {add_price[23:0], byte_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cancel_order_ref       <= '0;
      cancel_canceled_shares <= '0;
    end else if (cancel_take) begin
      if (in_field(cancel_cnt, OFF_OREF_LO, OFF_OREF_HI))
        cancel_order_ref <= {cancel_order_ref[55:0], byte_in};
      if (in_field(cancel_cnt, OFF_CXL_SHR_LO, OFF_CXL_SHR_HI))
        cancel_canceled_shares <= {cancel_canceled_shares[23:0], byte_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delete_order_ref <= '0;
    end else if (delete_take && in_field(delete_cnt, OFF_OREF_LO, OFF_OREF_HI)) begin
      delete_order_ref <= {delete_order_ref[55:0], byte_in};
    end
  end

endmodule

// File: tb/tb_itch_acd_decoder.sv
// Scoreboard bench for itch_acd_decoder: stimulus pushes expected pulses,
// a negedge monitor pops and compares whenever a valid/invalid pulse appears.
module tb_itch_acd_decoder;
  import itch_pkg::*;

  localparam int K_NONE    = 0;
  localparam int K_ADD     = 1;
  localparam int K_ADD_INV = 2;
  localparam int K_CXL     = 3;
  localparam int K_CXL_INV = 4;
  localparam int K_DEL     = 5;

  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0] oref;
    logic        side;
    logic [31:0] shares;
    logic [31:0] price;
    logic [63:0] sym;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        valid_in = 1'b0;
  logic        add_internal_valid, add_packet_invalid, add_side;
  logic [63:0] add_order_ref, add_stock_symbol;
  logic [31:0] add_shares, add_price;
  logic [3:0]  add_parsed_type;
  logic        cancel_internal_valid, cancel_packet_invalid;
  logic [63:0] cancel_order_ref;
  logic [31:0] cancel_canceled_shares;
  logic [3:0]  cancel_parsed_type;
  logic        delete_internal_valid;
  logic [63:0] delete_order_ref;
  logic [3:0]  delete_parsed_type;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  exp_t       sb[$];
  logic [7:0] msg[$];

  itch_acd_decoder dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .valid_in(valid_in),
    .add_internal_valid(add_internal_valid), .add_packet_invalid(add_packet_invalid),
    .add_order_ref(add_order_ref), .add_side(add_side), .add_shares(add_shares),
    .add_price(add_price), .add_stock_symbol(add_stock_symbol),
    .add_parsed_type(add_parsed_type),
    .cancel_internal_valid(cancel_internal_valid), .cancel_packet_invalid(cancel_packet_invalid),
    .cancel_order_ref(cancel_order_ref), .cancel_canceled_shares(cancel_canceled_shares),
    .cancel_parsed_type(cancel_parsed_type),
    .delete_internal_valid(delete_internal_valid), .delete_order_ref(delete_order_ref),
    .delete_parsed_type(delete_parsed_type)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mkExp(input int kind, input logic [63:0] oref, input logic side,
                                 input logic [31:0] shares, input logic [31:0] price,
                                 input logic [63:0] sym);
    exp_t e;
    e.kind = kind; e.cyc = 0; e.oref = oref; e.side = side;
    e.shares = shares; e.price = price; e.sym = sym;
    return e;
  endfunction

  task automatic pushHeader(input logic [7:0] t, input logic [63:0] oref);
    msg.delete();
    msg.push_back(t);
    for (int i = 1; i <= 10; i++) msg.push_back(8'(i));
    for (int b = 7; b >= 0; b--) msg.push_back(oref[b*8 +: 8]);
  endtask

  task automatic buildAdd(input logic [63:0] oref, input logic [7:0] side, input logic [31:0] shares,
                          input logic [63:0] sym, input logic [31:0] price);
    pushHeader(8'h41, oref);
    msg.push_back(side);
    for (int b = 3; b >= 0; b--) msg.push_back(shares[b*8 +: 8]);
    for (int b = 7; b >= 0; b--) msg.push_back(sym[b*8 +: 8]);
    for (int b = 3; b >= 0; b--) msg.push_back(price[b*8 +: 8]);
  endtask

  task automatic buildCancel(input logic [63:0] oref, input logic [31:0] shares);
    pushHeader(8'h58, oref);
    for (int b = 3; b >= 0; b--) msg.push_back(shares[b*8 +: 8]);
  endtask

  // Sends the first n bytes then one idle cycle; expectation timed one clock after its sampling edge
  task automatic applyStimulus(input int n, input exp_t e);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      byte_in  = msg[i];
      if (i == n - 1 && (e.kind == K_ADD || e.kind == K_CXL || e.kind == K_DEL)) begin
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    byte_in  = 8'h00;
    if (e.kind == K_ADD_INV || e.kind == K_CXL_INV) begin
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic checkOutput(input int kind);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_pulse got kind=%0d at cyc=%0d want no pulse", kind, cyc);
      return;
    end
    e = sb.pop_front();
    cmp("pulse_kind", 64'(kind), 64'(e.kind));
    cmp("pulse_cycle", 64'(cyc), 64'(e.cyc));
    if (kind != e.kind) return;
    case (kind)
      K_ADD: begin
        cmp("add_order_ref", add_order_ref, e.oref);
        cmp("add_side", 64'(add_side), 64'(e.side));
        cmp("add_shares", 64'(add_shares), 64'(e.shares));
        cmp("add_stock_symbol", add_stock_symbol, e.sym);
        cmp("add_price", 64'(add_price), 64'(e.price));
        cmp("add_parsed_type", 64'(add_parsed_type), 64'(1));
      end
      K_CXL: begin
        cmp("cancel_order_ref", cancel_order_ref, e.oref);
        cmp("cancel_canceled_shares", 64'(cancel_canceled_shares), 64'(e.shares));
        cmp("cancel_parsed_type", 64'(cancel_parsed_type), 64'(2));
      end
      K_DEL: begin
        cmp("delete_order_ref", delete_order_ref, e.oref);
        cmp("delete_parsed_type", 64'(delete_parsed_type), 64'(3));
      end
      default: ;
    endcase
  endtask

  task automatic checkResetState();
    cmp("rst_pulses", 64'({add_internal_valid, add_packet_invalid, cancel_internal_valid,
                           cancel_packet_invalid, delete_internal_valid}), 64'(0));
    cmp("rst_add_order_ref", add_order_ref, 64'(0));
    cmp("rst_add_misc", 64'({add_side, add_shares, add_price}), 64'(0));
    cmp("rst_add_symbol", add_stock_symbol, 64'(0));
    cmp("rst_cancel_order_ref", cancel_order_ref, 64'(0));
    cmp("rst_cancel_shares", 64'(cancel_canceled_shares), 64'(0));
    cmp("rst_delete_order_ref", delete_order_ref, 64'(0));
    cmp("rst_parsed_types", 64'({add_parsed_type, cancel_parsed_type, delete_parsed_type}), 64'(0));
  endtask

  always @(negedge clk) begin
    if (add_internal_valid)    checkOutput(K_ADD);
    if (add_packet_invalid)    checkOutput(K_ADD_INV);
    if (cancel_internal_valid) checkOutput(K_CXL);
    if (cancel_packet_invalid) checkOutput(K_CXL_INV);
    if (delete_internal_valid) checkOutput(K_DEL);
    cmp("idle_parsed_types",
        64'({add_parsed_type, cancel_parsed_type, delete_parsed_type}),
        64'({add_internal_valid ? 4'd1 : 4'd0, cancel_internal_valid ? 4'd2 : 4'd0,
             delete_internal_valid ? 4'd3 : 4'd0}));
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1 checkResetState();
    rst = 1'b0;

    buildAdd(64'h1234, 8'h53, 32'd100, 64'h4141504C20202020, 32'd1500000);
    applyStimulus(36, mkExp(K_ADD, 64'h1234, 1'b1, 32'd100, 32'd1500000, 64'h4141504C20202020));

    buildCancel(64'hDEADBEEF, 32'd50);
    applyStimulus(23, mkExp(K_CXL, 64'hDEADBEEF, 1'b0, 32'd50, 32'd0, 64'd0));

    pushHeader(8'h44, 64'd7);
    applyStimulus(19, mkExp(K_DEL, 64'd7, 1'b0, 32'd0, 32'd0, 64'd0));
    buildAdd(64'h55, 8'h53, 32'd1, 64'h49424D2020202020, 32'd99);
    applyStimulus(36, mkExp(K_ADD, 64'h55, 1'b1, 32'd1, 32'd99, 64'h49424D2020202020));
    buildCancel(64'h1122334455667788, 32'h0000FFFF);
    applyStimulus(23, mkExp(K_CXL, 64'h1122334455667788, 1'b0, 32'h0000FFFF, 32'd0, 64'd0));

    buildAdd(64'hAAAA, 8'h53, 32'd5, 64'h5858585820202020, 32'd7);
    applyStimulus(20, mkExp(K_ADD_INV, 64'd0, 1'b0, 32'd0, 32'd0, 64'd0));
    buildAdd(64'h0102030405060708, 8'h42, 32'hFFFFFFFF, 64'h4D53465420202020, 32'h12345678);
    applyStimulus(36, mkExp(K_ADD, 64'h0102030405060708, 1'b0, 32'hFFFFFFFF, 32'h12345678,
                            64'h4D53465420202020));

    buildCancel(64'h99, 32'd3);
    applyStimulus(15, mkExp(K_CXL_INV, 64'd0, 1'b0, 32'd0, 32'd0, 64'd0));
    pushHeader(8'h44, 64'h42);
    applyStimulus(18, mkExp(K_NONE, 64'd0, 1'b0, 32'd0, 32'd0, 64'd0));
    pushHeader(8'h44, 64'h43);
    applyStimulus(19, mkExp(K_DEL, 64'h43, 1'b0, 32'd0, 32'd0, 64'd0));

    msg.delete();
    msg.push_back(8'h50);
    for (int i = 1; i < 40; i++) msg.push_back(8'h41);
    applyStimulus(40, mkExp(K_NONE, 64'd0, 1'b0, 32'd0, 32'd0, 64'd0));

    buildCancel(64'hCAFE, 32'd9);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      byte_in  = msg[i];
    end
    @(posedge clk); #1;
    rst = 1'b1;
    valid_in = 1'b0;
    #1 checkResetState();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    buildCancel(64'hFEEDFACE12345678, 32'd77);
    applyStimulus(23, mkExp(K_CXL, 64'hFEEDFACE12345678, 1'b0, 32'd77, 32'd0, 64'd0));

    repeat (5) @(posedge clk);
    #1 cmp("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
